// File: rtl/demux_pkg.sv
// Shared types for the demux lane collector: lane select type, collector
// FSM states and the lane count.
package demux_pkg;

  localparam int LANES = 4;

  typedef logic [1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic logic [LANES-1:0] laneOneHot(lane_t lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/demux_lane_timeout.sv
// Idle-cycle counter for a partially filled frame; expire_o fires on the
// enabled cycle that would bring the count up to TIMEOUT.
module demux_lane_timeout #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  assign expire_o = enable_i && !clear_i && (count_q == LIMIT);

  always_comb begin
    count_d = count_q;
    if (clear_i || expire_o) begin
      count_d = 8'd0;
    end else if (enable_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/demux_lane_collector.sv
// Collects one data bit per demux lane into a 4-bit word and offers it on a
// valid/ready port; duplicate lanes and stalled frames abort with err_o.
module demux_lane_collector
  import demux_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       d_i,
  input  logic       s1_i,
  input  logic       s2_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [3:0] out_word_o,
  output logic       err_o
);

  state_e           state_q, state_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [LANES-1:0] capture_q, capture_d;
  logic [LANES-1:0] outWord_q, outWord_d;
  logic             outValid_q, outValid_d;
  logic             err_q, err_d;

  lane_t            lane;
  logic             accept;
  logic             outFree;
  logic             expire;
  logic [LANES-1:0] newMask;
  logic [LANES-1:0] newCapture;

  assign lane       = {s1_i, s2_i};
  assign in_ready_o = (state_q != HOLD);
  assign accept     = in_valid_i && in_ready_o;
  assign outFree    = !outValid_q || out_ready_i;
  assign newMask    = mask_q | laneOneHot(lane);

  always_comb begin
    newCapture       = capture_q;
    newCapture[lane] = d_i;
  end

  demux_lane_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (accept || (state_q != FILL)),
    .enable_i((state_q == FILL) && !accept),
    .expire_o(expire)
  );

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    capture_d  = capture_q;
    outWord_d  = outWord_q;
    outValid_d = outValid_q;
    err_d      = 1'b0;

    if (outValid_q && out_ready_i) begin
      outValid_d = 1'b0;
    end

    case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          // A repeated lane throws away the frame but seeds the next one.
          if (mask_q[lane]) begin
            err_d     = 1'b1;
            mask_d    = laneOneHot(lane);
            capture_d = newCapture;
            state_d   = FILL;
          end else if (newMask == '1) begin
            if (outFree) begin
              outWord_d  = newCapture;
              outValid_d = 1'b1;
              mask_d     = '0;
              state_d    = IDLE;
            end else begin
              mask_d    = newMask;
              capture_d = newCapture;
              state_d   = HOLD;
            end
          end else begin
            mask_d    = newMask;
            capture_d = newCapture;
            state_d   = FILL;
          end
        end else if (expire) begin
          err_d   = 1'b1;
          mask_d  = '0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (out_ready_i && outValid_q) begin
          outWord_d  = capture_q;
          outValid_d = 1'b1;
          mask_d     = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        mask_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      capture_q  <= '0;
      outWord_q  <= '0;
      outValid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      capture_q  <= capture_d;
      outWord_q  <= outWord_d;
      outValid_q <= outValid_d;
      err_q      <= err_d;
    end
  end

  assign out_valid_o = outValid_q;
  assign out_word_o  = outWord_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_demux_lane_collector.sv
// Directed bench for demux_lane_collector: a frame-level reference model is
// compared every cycle, plus literal expectations from worked scenarios.
module tb_demux_lane_collector;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inValid = 1'b0;
  logic       inReady;
  logic       dIn = 1'b0;
  logic       s1 = 1'b0;
  logic       s2 = 1'b0;
  logic       outValid;
  logic       outReady = 1'b1;
  logic [3:0] outWord;
  logic       err;

  int total = 0;
  int bad = 0;

  demux_lane_collector #(
    .TIMEOUT(TMO)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .d_i        (dIn),
    .s1_i       (s1),
    .s2_i       (s2),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .out_word_o (outWord),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  // Reference model: lanes seen so far in the current frame, an output slot
  // and one waiting frame that blocks input until the slot drains.
  bit       have[4];
  bit       val[4];
  int       idle;
  bit       mOutValid;
  bit [3:0] mOutWord;
  bit       pendFull;
  bit [3:0] pendWord;
  bit       mErr;

  function automatic int haveCount();
    int n = 0;
    for (int i = 0; i < 4; i++) n += have[i];
    return n;
  endfunction

  function automatic bit [3:0] frameWord();
    bit [3:0] w = 4'b0000;
    for (int i = 0; i < 4; i++) w[i] = val[i];
    return w;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      have[i] = 1'b0;
      val[i]  = 1'b0;
    end
    idle      = 0;
    mOutValid = 1'b0;
    mOutWord  = 4'b0000;
    pendFull  = 1'b0;
    pendWord  = 4'b0000;
    mErr      = 1'b0;
  endtask

  task automatic modelStep();
    bit acc;
    bit drain;
    int ln;
    acc   = inValid && !pendFull;
    drain = mOutValid && outReady;
    ln    = {s1, s2};
    mErr  = 1'b0;
    if (drain) mOutValid = 1'b0;
    if (pendFull) begin
      if (drain) begin
        mOutWord  = pendWord;
        mOutValid = 1'b1;
        pendFull  = 1'b0;
      end
    end else if (acc) begin
      idle = 0;
      if (have[ln]) begin
        mErr = 1'b1;
        for (int i = 0; i < 4; i++) have[i] = 1'b0;
      end
      have[ln] = 1'b1;
      val[ln]  = dIn;
      if (haveCount() == 4) begin
        if (mOutValid && !drain) begin
          pendWord = frameWord();
          pendFull = 1'b1;
        end else begin
          mOutWord  = frameWord();
          mOutValid = 1'b1;
        end
        for (int i = 0; i < 4; i++) have[i] = 1'b0;
      end
    end else if (haveCount() > 0) begin
      idle++;
      if (idle == TMO) begin
        mErr = 1'b1;
        idle = 0;
        for (int i = 0; i < 4; i++) have[i] = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else        modelStep();
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled just after each edge.
  always @(posedge clk) begin
    #2;
    checkOutput("in_ready", {3'b000, inReady}, {3'b000, !pendFull});
    checkOutput("out_valid", {3'b000, outValid}, {3'b000, mOutValid});
    checkOutput("err", {3'b000, err}, {3'b000, mErr});
    if (mOutValid) checkOutput("out_word", outWord, mOutWord);
  end

  task automatic applyStimulus(input bit v, input logic [1:0] lane, input bit dv, input bit ordy);
    @(negedge clk);
    inValid  = v;
    s1       = lane[1];
    s2       = lane[0];
    dIn      = dv;
    outReady = ordy;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    checkOutput("reset in_ready", {3'b000, inReady}, 4'b0001);
    checkOutput("reset out_valid", {3'b000, outValid}, 4'b0000);
    checkOutput("reset err", {3'b000, err}, 4'b0000);
    checkOutput("reset out_word", outWord, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // In-order lanes
    applyStimulus(1, 2'd0, 1, 1);
    applyStimulus(1, 2'd1, 0, 1);
    applyStimulus(1, 2'd2, 1, 1);
    applyStimulus(1, 2'd3, 1, 1);
    afterEdge();
    checkOutput("t1 valid", {3'b000, outValid}, 4'b0001);
    checkOutput("t1 word", outWord, 4'b1101);
    checkOutput("t1 err", {3'b000, err}, 4'b0000);

    // Permuted lanes, back-to-back with the previous frame
    applyStimulus(1, 2'd3, 1, 1);
    applyStimulus(1, 2'd0, 1, 1);
    applyStimulus(1, 2'd2, 0, 1);
    applyStimulus(1, 2'd1, 0, 1);
    afterEdge();
    checkOutput("t2 word", outWord, 4'b1001);

    // Second frame completes while the first is still held
    applyStimulus(0, 2'd0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 2'(i), 1, 0);
    applyStimulus(1, 2'd0, 0, 0);
    applyStimulus(1, 2'd1, 1, 0);
    applyStimulus(1, 2'd2, 0, 0);
    applyStimulus(1, 2'd3, 1, 0);
    afterEdge();
    checkOutput("t3 hold in_ready", {3'b000, inReady}, 4'b0000);
    checkOutput("t3 held word", outWord, 4'b1111);
    applyStimulus(1, 2'd0, 1, 1);
    afterEdge();
    checkOutput("t3 second word", outWord, 4'b1010);
    checkOutput("t3 ready again", {3'b000, inReady}, 4'b0001);
    applyStimulus(1, 2'd0, 1, 0);
    applyStimulus(1, 2'd1, 0, 1);
    applyStimulus(1, 2'd2, 0, 1);
    applyStimulus(1, 2'd3, 0, 1);
    afterEdge();
    checkOutput("t3 retried beat", outWord, 4'b0001);

    // Duplicate lane restarts the frame
    applyStimulus(1, 2'd0, 1, 1);
    applyStimulus(1, 2'd1, 1, 1);
    applyStimulus(1, 2'd1, 0, 1);
    afterEdge();
    checkOutput("t4 dup err", {3'b000, err}, 4'b0001);
    applyStimulus(1, 2'd0, 0, 1);
    afterEdge();
    checkOutput("t4 err one cycle", {3'b000, err}, 4'b0000);
    applyStimulus(1, 2'd2, 1, 1);
    applyStimulus(1, 2'd3, 1, 1);
    afterEdge();
    checkOutput("t4 word", outWord, 4'b1100);

    // Timeout after a single beat
    applyStimulus(1, 2'd2, 1, 1);
    repeat (3) applyStimulus(0, 2'd0, 0, 1);
    afterEdge();
    checkOutput("t5 no early err", {3'b000, err}, 4'b0000);
    applyStimulus(0, 2'd0, 0, 1);
    afterEdge();
    checkOutput("t5 timeout err", {3'b000, err}, 4'b0001);
    checkOutput("t5 no output", {3'b000, outValid}, 4'b0000);
    applyStimulus(0, 2'd0, 0, 1);
    afterEdge();
    checkOutput("t5 err cleared", {3'b000, err}, 4'b0000);

    // Reset mid-frame with a word on the output
    for (int i = 0; i < 4; i++) applyStimulus(1, 2'(i), (i == 1), 0);
    applyStimulus(1, 2'd0, 1, 0);
    applyStimulus(1, 2'd1, 1, 0);
    afterEdge();
    checkOutput("t6 pre-reset word", outWord, 4'b0010);
    @(negedge clk);
    inValid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t6 rst out_valid", {3'b000, outValid}, 4'b0000);
    checkOutput("t6 rst out_word", outWord, 4'b0000);
    checkOutput("t6 rst in_ready", {3'b000, inReady}, 4'b0001);
    checkOutput("t6 rst err", {3'b000, err}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1, 2'(i), 1, 1);
    afterEdge();
    checkOutput("t6 after reset", outWord, 4'b1111);
    applyStimulus(0, 2'd0, 0, 1);
    applyStimulus(0, 2'd0, 0, 1);
    afterEdge();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
